// File: rtl/imem_responder.sv
// Instruction-memory responder: answers one fetch read at a time after a fixed
// programmable latency, with a side load port for filling the program image.
module imem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AB    = DEPTH_LOG2 + 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AB-1:0]   addr_q, addr_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [AB-1:0]   rd_addr;
  logic            capture;
  logic [15:0]     rd_word;
  logic [15:0]     mem_q [DEPTH];
  logic            unused_addr_bits;

  // Handshakes: a request transfers on an edge where req_valid & req_ready;
  // a response transfers on an edge where rsp_valid & rsp_ready, and
  // rsp_data/rsp_err hold steady while rsp_valid waits for rsp_ready.

  assign unused_addr_bits = ^{req_addr[15:AB], ld_addr[15:AB], ld_addr[0]};

  // Read is taken from the pre-edge array, so a same-edge load is not seen.
  assign rd_word = mem_q[rd_addr[AB-1:1]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_addr = addr_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[AB-1:0];
          rd_addr = req_addr[AB-1:0];
          if (LATENCY == 1) begin
            capture = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (capture) begin
      rsp_err_d  = rd_addr[0];
      rsp_data_d = rd_addr[0] ? 16'h0000 : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Program image survives reset on purpose.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr[AB-1:1]] <= ld_data;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=4 and a LATENCY=1 instance run in lockstep
// against a transaction-level model of the array and the request lifecycle.
module tb_imem_responder;

  localparam int AW   = 10;
  localparam int NW   = 1 << AW;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [15:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic        ld_en     [2];
  logic [15:0] ld_addr   [2];
  logic [15:0] ld_data   [2];
  logic [1:0]  dbg_state [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Reference model: array image plus a pending-request record per instance.
  logic [15:0] mm [2][NW];
  bit          m_busy [2];
  bit          m_resp [2];
  int          m_edges [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_data [2];
  logic        m_err [2];
  int          acc_cyc [2];
  logic        prev_rv [2];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_LOG2(AW), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]),
    .dbg_state(dbg_state[0])
  );

  imem_responder #(.DEPTH_LOG2(AW), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]),
    .dbg_state(dbg_state[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = 1'b0;
      m_resp[d]  = 1'b0;
      m_edges[d] = 0;
      m_data[d]  = 16'h0000;
      m_err[d]   = 1'b0;
      prev_rv[d] = 1'b0;
    end
  endtask

  task automatic capture(input int d);
    m_resp[d] = 1'b1;
    m_err[d]  = m_addr[d][0];
    m_data[d] = m_addr[d][0] ? 16'h0000 : mm[d][int'(m_addr[d][AW:1])];
  endtask

  // One clock edge of the model; the load is applied after the read.
  task automatic model_edge(input int d);
    if (m_resp[d]) begin
      if (rsp_ready[d]) begin
        m_resp[d] = 1'b0;
        m_busy[d] = 1'b0;
      end
    end else if (m_busy[d]) begin
      m_edges[d]--;
      if (m_edges[d] == 0) capture(d);
    end else if (req_valid[d]) begin
      m_busy[d]  = 1'b1;
      m_addr[d]  = req_addr[d];
      acc_cyc[d] = cyc_n;
      m_edges[d] = lat(d) - 1;
      if (m_edges[d] == 0) capture(d);
    end
    if (ld_en[d]) mm[d][int'(ld_addr[d][AW:1])] = ld_data[d];
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d.req_ready", d), req_ready[d], !m_busy[d]);
      check($sformatf("d%0d.busy", d), busy[d], m_busy[d]);
      check($sformatf("d%0d.rsp_valid", d), rsp_valid[d], m_resp[d]);
      if (m_resp[d]) begin
        check($sformatf("d%0d.rsp_data", d), rsp_data[d], m_data[d]);
        check($sformatf("d%0d.rsp_err", d), rsp_err[d], m_err[d]);
      end
      if (rsp_valid[d] && !prev_rv[d])
        check($sformatf("d%0d.latency", d), cyc_n - acc_cyc[d], lat(d));
      prev_rv[d]   = rsp_valid[d];
      req_valid[d] = 1'b0;
      ld_en[d]     = 1'b0;
    end
  endtask

  task automatic request(input int d, input logic [15:0] a);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    cyc();
  endtask

  task automatic load(input int d, input logic [15:0] a, input logic [15:0] v);
    ld_en[d]   = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
  endtask

  task automatic wait_valid(input int d);
    int n = 0;
    while (!rsp_valid[d] && n < 40) begin
      cyc();
      n++;
    end
    if (!rsp_valid[d])
      check($sformatf("d%0d.timeout st=%0d", d, dbg_state[d]), rsp_valid[d], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int          n_rsp;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d]  = 16'h0000;
      rsp_ready[d] = 1'b1;
      ld_en[d]     = 1'b0;
      ld_addr[d]   = 16'h0000;
      ld_data[d]   = 16'h0000;
    end
    model_reset();

    // Reset values
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d.rst.req_ready", d), req_ready[d], 1'b1);
      check($sformatf("d%0d.rst.rsp_valid", d), rsp_valid[d], 1'b0);
      check($sformatf("d%0d.rst.rsp_data", d), rsp_data[d], 16'h0000);
      check($sformatf("d%0d.rst.rsp_err", d), rsp_err[d], 1'b0);
      check($sformatf("d%0d.rst.busy", d), busy[d], 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Fill the whole image with random words; bit 0 and upper bits vary.
    for (int w = 0; w < NW; w++) begin
      for (int d = 0; d < 2; d++)
        load(d, 16'(($urandom_range(0, 31) << 11) | (w << 1) | $urandom_range(0, 1)),
             16'($urandom));
      cyc();
    end

    // Basic read of a freshly loaded word
    load(0, 16'h0004, 16'hA5C3);
    cyc();
    request(0, 16'h0004);
    wait_valid(0);
    check("t1.data", rsp_data[0], 16'hA5C3);
    check("t1.err", rsp_err[0], 1'b0);
    cyc();

    // Backpressure with an ignored second request
    rsp_ready[0] = 1'b0;
    request(0, 16'h0010);
    wait_valid(0);
    held = rsp_data[0];
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = 1'b1;
      req_addr[0]  = 16'h0006;
      cyc();
      check("t2.stable", rsp_data[0], held);
      check("t2.no_accept", req_ready[0], 1'b0);
    end
    rsp_ready[0] = 1'b1;
    cyc();
    request(0, 16'h0006);
    check("t2.accept_next", busy[0], 1'b1);
    wait_valid(0);
    cyc();

    // Misaligned request and address wrap
    request(0, 16'h0007);
    wait_valid(0);
    check("t3.err", rsp_err[0], 1'b1);
    check("t3.data", rsp_data[0], 16'h0000);
    cyc();
    request(0, 16'h0804);
    wait_valid(0);
    check("t3.wrap", rsp_data[0], 16'hA5C3);
    cyc();

    // Load during WAIT is visible; load on the RESP-entry edge is not
    request(0, 16'h0004);
    load(0, 16'h0004, 16'h1234);
    cyc();
    wait_valid(0);
    check("t4.wait_load", rsp_data[0], 16'h1234);
    cyc();
    request(0, 16'h0004);
    for (int i = 0; i < LAT0 - 2; i++) cyc();
    load(0, 16'h0005, 16'h5678);
    cyc();
    check("t4.entry_valid", rsp_valid[0], 1'b1);
    check("t4.entry_old", rsp_data[0], 16'h1234);
    cyc();
    request(0, 16'h0004);
    wait_valid(0);
    check("t4.new", rsp_data[0], 16'h5678);
    cyc();

    // Asynchronous reset while waiting
    request(0, 16'h0010);
    cyc();
    #2 rst = 1'b0;
    #1;
    check("t5.busy", busy[0], 1'b0);
    check("t5.req_ready", req_ready[0], 1'b1);
    check("t5.rsp_valid", rsp_valid[0], 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    request(0, 16'h0004);
    wait_valid(0);
    check("t5.preserved", rsp_data[0], 16'h5678);
    cyc();

    // LATENCY=1 back-to-back
    n_rsp = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid[1] = 1'b1;
      req_addr[1]  = 16'($urandom_range(0, 15) << 1);
      cyc();
      if (rsp_valid[1]) n_rsp++;
    end
    check("t6.rsp_count", n_rsp, 8);
    cyc();

    // Random traffic on both instances, loads aimed at the requested words
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++) begin
        rsp_ready[d] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          req_valid[d] = 1'b1;
          req_addr[d]  = 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 7) << 1) |
                             ($urandom_range(0, 7) == 0 ? 1 : 0));
        end
        if ($urandom_range(0, 2) == 0)
          load(d, 16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 7) << 1) |
                      $urandom_range(0, 1)), 16'($urandom));
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
